// File: rtl/hps_pio_pkg.sv
// Shared register-map and edge-type constants for the HPS input PIO.
package hps_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/hps_pio_in_debounce.sv
// Single-bit debouncer: output follows input only after it has differed
// for DEBOUNCE_CYCLES consecutive clocks.
module hps_pio_in_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_s,
  output logic o_f
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_f   <= 1'b0;
    end else if (i_s == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_f   <= i_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_f = r_f;

endmodule

// File: rtl/hps_pio_in_irq.sv
// Avalon-MM input PIO: synchroniser, optional debounce (HPS_PIO_IN_DEBOUNCE_EN),
// per-bit edge capture with write-1-to-clear and a maskable level IRQ.
module hps_pio_in_irq
  import hps_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_fd;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdmux;
  logic             w_wr;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef HPS_PIO_IN_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    hps_pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_s     (w_s[gi]),
      .o_f     (w_f[gi])
    );
  end
`else
  assign w_f = w_s;
`endif

  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign w_edge = ~w_f & r_fd;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign w_edge = w_f ^ r_fd;
  end else begin : g_rise
    assign w_edge = w_f & ~r_fd;
  end

  assign w_wr  = chipselect & write;
  assign w_clr = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdmux = '0;
    case (pio_addr_e'(address))
      ADDR_DATA: w_rdmux[WIDTH-1:0] = w_f;
      ADDR_RSVD: ;
      ADDR_MASK: w_rdmux[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rdmux[WIDTH-1:0] = r_edgecap;
    endcase
  end

  // Clear is applied before OR-ing new edges so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fd       <= '0;
      r_mask     <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
    end else begin
      r_fd       <= w_f;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      r_readdata <= w_rdmux;
      if (w_wr && address == ADDR_MASK) r_mask <= writedata[WIDTH-1:0];
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_mask);

  assign w_unused = ^{writedata, 1'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_hps_pio_in_irq.sv
// Directed bench: DUT A is 32-bit rising-edge, DUT B is 8-bit falling-edge.
module tb_hps_pio_in_irq;

`ifdef HPS_PIO_IN_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic        clk;
  logic        reset_n;

  logic [1:0]  a_address;
  logic        a_cs;
  logic        a_write;
  logic [31:0] a_wd;
  logic [31:0] a_in;
  logic [31:0] a_readdata;
  logic        a_irq;

  logic [1:0]  b_address;
  logic        b_cs;
  logic        b_write;
  logic [31:0] b_wd;
  logic [7:0]  b_in;
  logic [31:0] b_readdata;
  logic        b_irq;

  int n_vec;
  int n_err;
  logic [31:0] d;

  hps_pio_in_irq #(
    .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(a_address), .chipselect(a_cs),
    .write(a_write), .writedata(a_wd), .in_port(a_in),
    .readdata(a_readdata), .irq(a_irq)
  );

  hps_pio_in_irq #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_address), .chipselect(b_cs),
    .write(b_write), .writedata(b_wd), .in_port(b_in),
    .readdata(b_readdata), .irq(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_wr(input logic [1:0] ad, input logic [31:0] wd);
    a_address = ad; a_cs = 1'b1; a_write = 1'b1; a_wd = wd;
    @(negedge clk);
    a_cs = 1'b0; a_write = 1'b0;
  endtask

  task automatic a_rdd(input logic [1:0] ad, output logic [31:0] q);
    a_address = ad;
    @(negedge clk);
    q = a_readdata;
  endtask

  task automatic b_wr(input logic [1:0] ad, input logic [31:0] wd);
    b_address = ad; b_cs = 1'b1; b_write = 1'b1; b_wd = wd;
    @(negedge clk);
    b_cs = 1'b0; b_write = 1'b0;
  endtask

  task automatic b_rdd(input logic [1:0] ad, output logic [31:0] q);
    b_address = ad;
    @(negedge clk);
    q = b_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0;
    a_address = 2'd0; a_cs = 1'b0; a_write = 1'b0; a_wd = '0; a_in = 32'hFFFF_FFFF;
    b_address = 2'd0; b_cs = 1'b0; b_write = 1'b0; b_wd = '0; b_in = 8'h00;

    tick(3);
    check_vec("rst_readdata", a_readdata, 32'h0);
    check_vec("rst_irq", {31'b0, a_irq}, 32'h0);

    // Input held high through reset shows up as a rising edge after release.
    reset_n = 1'b1;
    tick(2 + DB);
    check_vec("rel_data_early", a_readdata, 32'h0);
    tick(1);
    check_vec("rel_data", a_readdata, 32'hFFFF_FFFF);
    a_rdd(2'd3, d); check_vec("rel_edge", d, 32'hFFFF_FFFF);
    check_vec("rel_irq", {31'b0, a_irq}, 32'h0);
    a_rdd(2'd2, d); check_vec("rel_mask", d, 32'h0);

    a_wr(2'd3, 32'hFFFF_FFFF);
    a_in = 32'h0;
    tick(5 + 2 * DB);
    a_rdd(2'd3, d); check_vec("clr_all", d, 32'h0);

    a_wr(2'd2, 32'h5);
    a_rdd(2'd2, d); check_vec("mask_rb", d, 32'h5);
    a_in = 32'h4;
    tick(2 + DB);
    check_vec("irq_before", {31'b0, a_irq}, 32'h0);
    tick(1);
    check_vec("irq_rise", {31'b0, a_irq}, 32'h1);
    tick(1);
    a_in = 32'h0;
    tick(4 + 2 * DB);
    a_rdd(2'd3, d); check_vec("edge_b2", d, 32'h4);
    a_wr(2'd3, 32'h4);
    check_vec("irq_clr", {31'b0, a_irq}, 32'h0);
    a_rdd(2'd3, d); check_vec("edge_b2_clr", d, 32'h0);

    a_in = 32'h2;
    tick(4 + DB);
    a_in = 32'h0;
    tick(4 + 2 * DB);
    a_rdd(2'd3, d); check_vec("edge_b1", d, 32'h2);
    check_vec("irq_masked", {31'b0, a_irq}, 32'h0);
    a_wr(2'd3, 32'h2);

    // Clear write lands on the same edge that captures the rising edge.
    a_in = 32'h1;
    tick(2 + DB);
    a_wr(2'd3, 32'h1);
    a_rdd(2'd3, d); check_vec("set_wins", d, 32'h1);
    check_vec("set_wins_irq", {31'b0, a_irq}, 32'h1);
    a_wr(2'd3, 32'h1);
    a_rdd(2'd3, d); check_vec("clr_after", d, 32'h0);

    a_wr(2'd1, 32'hFFFF_FFFF);
    a_rdd(2'd1, d); check_vec("rsvd", d, 32'h0);
    a_rdd(2'd0, d); check_vec("data_b0", d, 32'h1);

    b_rdd(2'd3, d); check_vec("b_edge_init", d, 32'h0);
    b_in = 8'h81;
    tick(4 + DB);
    b_rdd(2'd3, d); check_vec("b_no_rise", d, 32'h0);
    b_in = 8'h01;
    tick(4 + DB);
    b_rdd(2'd3, d); check_vec("b_fall", d, 32'h80);
    b_rdd(2'd0, d); check_vec("b_data", d, 32'h1);
    check_vec("b_irq_off", {31'b0, b_irq}, 32'h0);
    b_wr(2'd2, 32'hFFFF_FFFF);
    b_rdd(2'd2, d); check_vec("b_mask_trunc", d, 32'hFF);
    check_vec("b_irq_on", {31'b0, b_irq}, 32'h1);

    a_wr(2'd2, 32'hF);
    a_in = 32'hB;
    tick(4 + DB);
    a_rdd(2'd3, d); check_vec("pre_rst_edge", d, 32'hA);
    check_vec("pre_rst_irq", {31'b0, a_irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_vec("async_irq", {31'b0, a_irq}, 32'h0);
    check_vec("async_rd", a_readdata, 32'h0);
    a_in = 32'h0;
    b_in = 8'h00;
    tick(2);
    reset_n = 1'b1;
    tick(5 + DB);
    a_rdd(2'd2, d); check_vec("post_mask", d, 32'h0);
    a_rdd(2'd3, d); check_vec("post_edge", d, 32'h0);
    a_rdd(2'd0, d); check_vec("post_data", d, 32'h0);
    b_rdd(2'd2, d); check_vec("post_b_mask", d, 32'h0);

`ifdef HPS_PIO_IN_DEBOUNCE_EN
    a_in = 32'h1;
    tick(3);
    a_in = 32'h0;
    tick(10);
    a_rdd(2'd0, d); check_vec("db_glitch_data", d, 32'h0);
    a_rdd(2'd3, d); check_vec("db_glitch_edge", d, 32'h0);
    a_in = 32'h1;
    tick(6);
    a_rdd(2'd0, d); check_vec("db_hold_data", d, 32'h1);
    a_rdd(2'd3, d); check_vec("db_hold_edge", d, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
